// File: rtl/iiitb_plifo.sv
// rtl/iiitb_plifo.sv - parametrised single-clock LIFO stack with flags and sticky errors
module iiitb_plifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  input  logic             Clr,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic [CW-1:0]    count,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_EMPTY,
  output logic             ALMOST_FULL,
  output logic             OVF,
  output logic             UNF
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] mem_wa;
  logic          mem_we;
  logic          do_push;
  logic          do_pop;
  logic          do_rep;
  logic          do_byp;
  logic          ovf_set;
  logic          unf_set;

  assign EMPTY        = (count == '0);
  assign FULL         = (count == DEPTH_C);
  assign ALMOST_EMPTY = (count <= AE_C);
  assign ALMOST_FULL  = (count >= AF_C);
  assign top_idx      = AW'(count - CW'(1));

  // Request decode; Clr and a low EN both suppress every stack operation.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_rep  = 1'b0;
    do_byp  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!Clr && EN) begin
      case ({Push, Pop})
        2'b10: begin
          do_push = !FULL;
          ovf_set = FULL;
        end
        2'b01: begin
          do_pop  = !EMPTY;
          unf_set = EMPTY;
        end
        2'b11: begin
          do_rep = !EMPTY;
          do_byp = EMPTY;
        end
        default: ;
      endcase
    end
  end

  assign mem_we = (do_push || do_rep) && !Rst;
  assign mem_wa = do_push ? AW'(count) : top_idx;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_wa] <= dataIn;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else if (Clr) begin
      count     <= '0;
      dataValid <= 1'b0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else begin
      dataValid <= do_pop || do_rep || do_byp;
      if (do_push) begin
        count <= count + CW'(1);
      end
      if (do_pop) begin
        count <= count - CW'(1);
      end
      // Replace reads the old top while the same edge overwrites it.
      if (do_pop || do_rep) begin
        dataOut <= mem[top_idx];
      end
      if (do_byp) begin
        dataOut <= dataIn;
      end
      if (ovf_set) begin
        OVF <= 1'b1;
      end
      if (unf_set) begin
        UNF <= 1'b1;
      end
    end
  end

endmodule
